aes_128_inv: RTL and testbench

AES_128_INV -- requirements
Module: aes_128_inv

---
 rtl/aes_128_inv.sv | 184 ++++++++++++++++++
 tb/tb_aes_128_inv.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_inv.sv
// AES-128 iterative decryptor: on-the-fly key expansion to K10, then the inverse rounds, walking the key schedule back down.
// Latency: 21 clk edges from the accepting edge until valid; one round per cycle.
// Backpressure: a start is taken only while ready=1 (IDLE/DONE); start while busy is dropped, not queued.
module aes_128_inv (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] in_bus,
   input  logic [127:0] key,
   output logic [127:0] out_bus,
   output logic         ready,
   output logic         valid
);

   typedef enum logic [2:0] {IDLE, EXPAND, ADDKEY, ROUND, FINAL, DONE} fsm_t;

   // Byte x of each table sits at bits {~x,3'b111} -: 8 (entry 0 in the MSBs).
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // GF(2^8) multiply by a 4-bit constant (InvMixColumns only needs 9, b, d, e).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // InvShiftRows then InvSubBytes; byte r+4c is row r, column c.
   function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 32] = {
            gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
      end
      return o;
   endfunction

   fsm_t         fsm;
   logic [3:0]   idx;
   logic [127:0] state_reg;
   logic [127:0] key_reg;

   // Key schedule step: forward (EXPAND) and inverse share one SubWord; they differ only in its input word.
   logic [31:0]  w0, w1, w2, w3, sw_in, sw_out, rk, nw0;
   logic [3:0]   rc_idx;
   logic [127:0] fwd_key, inv_key, sr_sb_ark;

   assign w0      = key_reg[127:96];
   assign w1      = key_reg[95:64];
   assign w2      = key_reg[63:32];
   assign w3      = key_reg[31:0];
   assign rc_idx  = (fsm == EXPAND) ? idx : (fsm == ADDKEY) ? 4'd9 : idx - 4'd1;
   assign sw_in   = (fsm == EXPAND) ? w3 : (w3 ^ w2);
   assign sw_out  = sub_word({sw_in[23:0], sw_in[31:24]});
   assign rk      = {rcon(rc_idx), 24'h0};
   assign nw0     = w0 ^ sw_out ^ rk;
   assign fwd_key = {nw0, w1 ^ nw0, w2 ^ w1 ^ nw0, w3 ^ w2 ^ w1 ^ nw0};
   assign inv_key = {nw0, w1 ^ w0, w2 ^ w1, w3 ^ w2};

   // Common front half of a decryption round, shared by ROUND and FINAL.
   assign sr_sb_ark = inv_sr_sb(state_reg) ^ key_reg;

   // Control FSM with registered ready/valid; state_reg/key_reg carry no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm     <= IDLE;
         idx     <= 4'd0;
         out_bus <= '0;
         valid   <= 1'b0;
         ready   <= 1'b1;
      end else begin
         case (fsm)
            IDLE, DONE: begin
               if (start) begin
                  state_reg <= in_bus;
                  key_reg   <= key;
                  idx       <= 4'd0;
                  fsm       <= EXPAND;
                  ready     <= 1'b0;
                  valid     <= 1'b0;
               end
            end
            EXPAND: begin
               key_reg <= fwd_key;
               idx     <= idx + 4'd1;
               if (idx == 4'd9) fsm <= ADDKEY;
            end
            ADDKEY: begin
               state_reg <= state_reg ^ key_reg;
               key_reg   <= inv_key;
               idx       <= 4'd9;
               fsm       <= ROUND;
            end
            ROUND: begin
               state_reg <= inv_mix_cols(sr_sb_ark);
               key_reg   <= inv_key;
               idx       <= idx - 4'd1;
               if (idx == 4'd1) fsm <= FINAL;
            end
            FINAL: begin
               out_bus <= sr_sb_ark;
               fsm     <= DONE;
               ready   <= 1'b1;
               valid   <= 1'b1;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_128_inv.sv
// Bench for aes_128_inv: reference AES built from GF(2^8) arithmetic, cycle-level ready/valid/out_bus model.
// Directed FIPS-197 vectors, back-to-back, busy-ignore, mid-operation reset, then random round trips.
// Inputs driven on the falling edge, outputs checked on the falling edge.
module tb_aes_128_inv;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [127:0] in_bus, key, out_bus;
   logic         ready, valid;

   aes_128_inv dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .in_bus (in_bus),
      .key    (key),
      .out_bus(out_bus),
      .ready  (ready),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   int   n_chk  = 0;
   int   n_fail = 0;
   logic chk_en = 1'b0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference AES ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box = affine map of the multiplicative inverse; inverse S-box by table inversion.
   task automatic build_tables();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gf_mul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      for (int a = 0; a < 256; a++) isb[sb[a]] = a[7:0];
   endtask

   function automatic logic [7:0] get_b(input logic [127:0] v, input int i);
      return v[127 - 8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv ? isb[get_b(v, i)] : sb[get_b(v, i)];
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
      logic [127:0] o;
      int src;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127 - 8*(r + 4*c) -: 8] = get_b(v, r + 4*src);
         end
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] v, input bit inv);
      logic [127:0] o;
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k - r + 4) % 4], get_b(v, k + 4*c));
            o[127 - 8*(r + 4*c) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [127:0] s;
      s = pt ^ round_key(k, 0);
      for (int r = 1; r < 10; r++) s = mix_cols(shift_rows(sub_bytes(s, 0), 0), 0) ^ round_key(k, r);
      return shift_rows(sub_bytes(s, 0), 0) ^ round_key(k, 10);
   endfunction

   function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] k);
      logic [127:0] s;
      s = ct ^ round_key(k, 10);
      for (int r = 9; r > 0; r--) s = mix_cols(sub_bytes(shift_rows(s, 1), 1) ^ round_key(k, r), 1);
      return sub_bytes(shift_rows(s, 1), 1) ^ round_key(k, 0);
   endfunction

   // ---------------- cycle model: busy countdown of 21 edges ----------------
   int           m_cnt;
   logic         m_ready, m_valid;
   logic [127:0] m_out, m_pend;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt   <= 0;
         m_ready <= 1'b1;
         m_valid <= 1'b0;
         m_out   <= '0;
      end else if (m_ready && start) begin
         m_pend  <= aes_dec(in_bus, key);
         m_cnt   <= 21;
         m_ready <= 1'b0;
         m_valid <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_ready <= 1'b1;
            m_valid <= 1'b1;
            m_out   <= m_pend;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_ready",   128'(ready),   128'(m_ready));
         check("cyc_valid",   128'(valid),   128'(m_valid));
         check("cyc_out_bus", out_bus,       m_out);
      end
   end

   // ---------------- stimulus ----------------
   // mode 0: single start pulse; 1: start held high; 2: noise on start/in_bus/key while busy.
   task automatic run_op(input string name, input logic [127:0] ct, input logic [127:0] k,
                         input logic [127:0] exp_pt, input int mode);
      int busy;
      int rdy_low;
      busy    = 0;
      rdy_low = 0;
      start   = 1'b1;
      in_bus  = ct;
      key     = k;
      @(negedge clk);
      while (!valid && busy < 60) begin
         busy++;
         if (!ready) rdy_low++;
         if (mode == 0) start = 1'b0;
         else if (mode == 2) begin
            start  = 1'($urandom_range(0, 1));
            in_bus = {$urandom, $urandom, $urandom, $urandom};
            key    = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({name, "_latency"},   128'(busy),    128'd21);
      check({name, "_ready_low"}, 128'(rdy_low), 128'd21);
      check({name, "_valid"},     128'(valid),   128'd1);
      check({name, "_out_bus"},   out_bus,       exp_pt);
   endtask

   initial begin
      logic [127:0] rk, rp;
      rst    = 1'b1;
      start  = 1'b0;
      in_bus = '0;
      key    = '0;

      build_tables();
      check("model_sbox_00",    128'(sb[8'h00]),  128'h63);
      check("model_sbox_53",    128'(sb[8'h53]),  128'hed);
      check("model_invsbox_00", 128'(isb[8'h00]), 128'h52);
      check("model_c1_enc", aes_enc(C1_PT, C1_KEY), C1_CT);
      check("model_c1_dec", aes_dec(C1_CT, C1_KEY), C1_PT);
      check("model_b_enc",  aes_enc(B_PT, B_KEY),   B_CT);
      check("model_b_dec",  aes_dec(B_CT, B_KEY),   B_PT);

      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_ready",   128'(ready), 128'd1);
      check("reset_valid",   128'(valid), 128'd0);
      check("reset_out_bus", out_bus,     128'h0);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 C.1, then B back-to-back with start held from DONE
      run_op("c1", C1_CT, C1_KEY, C1_PT, 0);
      run_op("b_b2b", B_CT, B_KEY, B_PT, 1);

      // DONE holds its result with no start
      repeat (5) @(negedge clk);
      check("hold_valid",   128'(valid), 128'd1);
      check("hold_out_bus", out_bus,     B_PT);

      // Start toggling and random inputs while busy are ignored
      run_op("busy_ignore", C1_CT, C1_KEY, C1_PT, 2);

      // Reset mid-operation, with start asserted on the reset edge
      start  = 1'b1;
      in_bus = B_CT;
      key    = B_KEY;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check("midrst_ready",   128'(ready), 128'd1);
      check("midrst_valid",   128'(valid), 128'd0);
      check("midrst_out_bus", out_bus,     128'h0);
      rst   = 1'b0;
      start = 1'b0;
      repeat (25) @(negedge clk);
      check("midrst_no_pulse", 128'(valid), 128'd0);
      run_op("after_rst_c1", C1_CT, C1_KEY, C1_PT, 0);

      // Random round trips
      for (int n = 0; n < 1000; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         run_op("rand", aes_enc(rp, rk), rk, rp, 0);
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
